// File: rtl/trace_event_extract.sv
// Trace monitor front end: decodes simulation-control l.nop K instructions from the
// wb stage into a buffered first-word-fall-through event stream, and tracks this
// tile's termination plus the all-tiles-done aggregate.
module trace_event_extract #(
    parameter int unsigned ID             = 0,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TERM_CROSS_NUM = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [31:0]               wb_pc,
    input  logic [31:0]               wb_insn,
    input  logic [31:0]               r3,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [1:0]                ev_type,
    output logic [31:0]               ev_data,
    output logic [31:0]               ev_pc,
    output logic [15:0]               ev_id,
    output logic                      terminated,
    input  logic [TERM_CROSS_NUM-1:0] termination_all,
    output logic                      all_done,
    output logic                      overflow
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    localparam logic [1:0] EV_EXIT   = 2'd0;
    localparam logic [1:0] EV_REPORT = 2'd1;
    localparam logic [1:0] EV_PUTC   = 2'd2;

    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] data;
        logic [31:0] pc;
    } ev_entry_t;

    ev_entry_t              mem [FIFO_DEPTH];
    ev_entry_t              new_entry;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic                   dec_valid;
    logic                   dec_exit;
    logic [1:0]             dec_type;
    logic                   pop;
    logic                   push;

    assign ev_id = 16'(ID);

    // Decode the retiring instruction into an event request; gated once terminated
    always_comb begin
        dec_valid = 1'b0;
        dec_exit  = 1'b0;
        dec_type  = EV_EXIT;
        if (enable && !terminated && (wb_insn[31:16] == 16'h1500)) begin
            case (wb_insn[15:0])
                16'd1: begin
                    dec_valid = 1'b1;
                    dec_exit  = 1'b1;
                    dec_type  = EV_EXIT;
                end
                16'd2: begin
                    dec_valid = 1'b1;
                    dec_type  = EV_REPORT;
                end
                16'd4: begin
                    dec_valid = 1'b1;
                    dec_type  = EV_PUTC;
                end
                default: ;
            endcase
        end
    end

    // Build the entry and the push/pop handshake; a full FIFO still accepts on a same-cycle pop
    always_comb begin
        new_entry.typ  = dec_type;
        new_entry.data = (dec_type == EV_PUTC) ? {24'b0, r3[7:0]} : r3;
        new_entry.pc   = wb_pc;
        pop            = ev_valid && ev_ready;
        push           = dec_valid && ((count < DEPTH_C) || pop);
        count_next     = count;
        if (push && !pop) begin
            count_next = count + ONE_C;
        end else if (pop && !push) begin
            count_next = count - ONE_C;
        end
    end

    // Entry storage; contents are only meaningful between rd_ptr and wr_ptr
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy and the registered head of the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ev_valid <= 1'b0;
            ev_type  <= '0;
            ev_data  <= '0;
            ev_pc    <= '0;
        end else begin
            count    <= count_next;
            ev_valid <= (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Head follows the oldest surviving entry; holds the last shown value when empty
            if (push && ((count == '0) || (pop && (count == ONE_C)))) begin
                ev_type <= new_entry.typ;
                ev_data <= new_entry.data;
                ev_pc   <= new_entry.pc;
            end else if (pop && (count > ONE_C)) begin
                ev_type <= mem[rd_ptr + PTR_W'(1)].typ;
                ev_data <= mem[rd_ptr + PTR_W'(1)].data;
                ev_pc   <= mem[rd_ptr + PTR_W'(1)].pc;
            end
        end
    end

    // Sticky status flags: own termination, global completion, dropped events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            terminated <= 1'b0;
            all_done   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (dec_exit) begin
                terminated <= 1'b1;
            end
            all_done <= all_done | (&termination_all);
            if (dec_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
